// File: rtl/ahb2wb_burst.sv
`default_nettype none
// ============================================================================
// Module   : ahb2wb_burst
// Purpose  : AHB-Lite slave to Wishbone B3 master bridge with burst support.
//            Every AHB beat becomes one registered-feedback Wishbone beat.
//            INCRx/WRAPx bursts are tagged with cti_o/bte_o, and the Wishbone
//            cycle is held open across BUSY beats and back-to-back transfers.
//            Wishbone errors and ack timeouts become two-cycle AHB ERRORs.
// Ports    : hclk, hresetn            clock, synchronous active-low reset
//            hsel/haddr/htrans/hwrite AHB address phase
//            hsize/hburst/hwdata      AHB size, burst type, write data
//            hrdata/hready/hresp      AHB slave response (registered)
//            adr_o/dat_o/sel_o/we_o   Wishbone master request
//            cyc_o/stb_o/cti_o/bte_o  Wishbone cycle control (registered)
//            dat_i/ack_i/err_i        Wishbone slave response
// Revision : 1.0 - initial release
// ============================================================================
module ahb2wb_burst #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [AWIDTH-1:0]     haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DWIDTH-1:0]     hwdata,
  output logic [DWIDTH-1:0]     hrdata,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic [AWIDTH-1:0]     adr_o,
  output logic [DWIDTH-1:0]     dat_o,
  input  logic [DWIDTH-1:0]     dat_i,
  output logic [DWIDTH/8-1:0]   sel_o,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic [2:0]            cti_o,
  output logic [1:0]            bte_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int c_NSEL = DWIDTH / 8;
  localparam int c_LSB  = $clog2(c_NSEL);
  localparam int c_TW   = $clog2(TIMEOUT + 2);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] c_BUSY   = 2'b01;
  localparam logic [1:0] c_NONSEQ = 2'b10;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_ERROR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_DONE   = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_beat;
  logic [c_TW-1:0]   r_tmo;

  logic              w_accept;
  logic              w_size_ok;
  logic              w_fixed;
  logic              w_wrap;
  logic [3:0]        w_last_idx;
  logic [3:0]        w_beat_nxt;
  logic [2:0]        w_cti;
  logic [1:0]        w_bte;
  logic [c_LSB-1:0]  w_mask;
  logic [c_LSB-1:0]  w_off;
  logic [c_NSEL-1:0] w_lanes;
  logic [c_NSEL-1:0] w_sel;
  logic              w_tmo;

  // hwdata is held by the master while hready is low, so no capture is needed.
  assign dat_o = hwdata;

  assign w_accept  = hsel & hready & htrans[1];
  assign w_size_ok = (hsize <= 3'(c_LSB));
  assign w_tmo     = (TIMEOUT != 0) && (r_tmo == c_TMO_LAST);

  // Burst decode: hburst[2:1] gives the fixed length (4/8/16), hburst[0]=0 marks wrap.
  always_comb begin
    w_fixed    = (hburst[2:1] != 2'b00);
    w_wrap     = w_fixed & ~hburst[0];
    w_last_idx = 4'd0;
    case (hburst[2:1])
      2'b01:   w_last_idx = 4'd3;
      2'b10:   w_last_idx = 4'd7;
      2'b11:   w_last_idx = 4'd15;
      default: w_last_idx = 4'd0;
    endcase
    w_beat_nxt = (htrans == c_NONSEQ) ? 4'd0 : (r_beat + 4'd1);
    if (!w_fixed)
      w_cti = 3'b000;
    else if (w_beat_nxt == w_last_idx)
      w_cti = 3'b111;
    else
      w_cti = 3'b010;
    w_bte = w_wrap ? hburst[2:1] : 2'b00;
  end

  // Byte lanes: 2^hsize contiguous lanes starting at the size-aligned offset.
  always_comb begin
    w_mask  = c_LSB'((32'd1 << hsize) - 32'd1);
    w_off   = haddr[c_LSB-1:0] & ~w_mask;
    w_lanes = c_NSEL'((32'd1 << (32'd1 << hsize)) - 32'd1);
    w_sel   = w_lanes << w_off;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_tmo   <= '0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      sel_o   <= '0;
      cti_o   <= 3'b000;
      bte_o   <= 2'b00;
      hrdata  <= '0;
      hready  <= 1'b1;
      hresp   <= c_OKAY;
    end else begin
      case (r_state)
        S_ACCESS: begin
          if (err_i || w_tmo) begin
            // err_i takes priority over a simultaneous ack_i.
            r_state <= S_ERR1;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            hresp   <= c_ERROR;
          end else if (ack_i) begin
            r_state <= S_DONE;
            stb_o   <= 1'b0;
            hready  <= 1'b1;
            if (!we_o)
              hrdata <= dat_i;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_ERR1: begin
          r_state <= S_ERR2;
          hready  <= 1'b1;
        end

        default: begin
          // IDLE, DONE and ERR2 all drive hready high and may take a new beat.
          if (w_accept) begin
            r_beat <= w_beat_nxt;
            r_tmo  <= '0;
            hready <= 1'b0;
            if (w_size_ok) begin
              r_state <= S_ACCESS;
              adr_o   <= haddr;
              we_o    <= hwrite;
              sel_o   <= w_sel;
              cti_o   <= w_cti;
              bte_o   <= w_bte;
              cyc_o   <= 1'b1;
              stb_o   <= 1'b1;
              hresp   <= c_OKAY;
            end else begin
              // Unsupported size: answer ERROR without touching the bus.
              r_state <= S_ERR1;
              cyc_o   <= 1'b0;
              stb_o   <= 1'b0;
              hresp   <= c_ERROR;
            end
          end else if ((r_state == S_DONE) && hsel && (htrans == c_BUSY)) begin
            // BUSY keeps the Wishbone cycle open with zero-wait OKAY.
            stb_o <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            hready  <= 1'b1;
            hresp   <= c_OKAY;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb2wb_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb2wb_burst
// Purpose  : Self-checking bench for ahb2wb_burst. Drives AHB bursts and acts
//            as the Wishbone slave; expected bus values come from burst-level
//            arithmetic (beat addresses, lane spans, burst positions).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2wb_burst;

  localparam int c_AW  = 16;
  localparam int c_DW  = 32;
  localparam int c_TMO = 8;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic              hsel;
  logic [c_AW-1:0]   haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [c_DW-1:0]   hwdata;
  logic [c_DW-1:0]   hrdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [c_AW-1:0]   adr_o;
  logic [c_DW-1:0]   dat_o;
  logic [c_DW-1:0]   dat_i;
  logic [3:0]        sel_o;
  logic              we_o;
  logic              cyc_o;
  logic              stb_o;
  logic [2:0]        cti_o;
  logic [1:0]        bte_o;
  logic              ack_i;
  logic              err_i;

  int n_tests = 0;
  int n_fail  = 0;

  ahb2wb_burst #(.AWIDTH(c_AW), .DWIDTH(c_DW), .TIMEOUT(c_TMO)) u_dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
    .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o),
    .bte_o(bte_o), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  // ---------------- reference model ----------------
  function automatic int burst_len(input logic [2:0] hb);
    if (hb < 3'd2) return 0;
    return 2 << (hb >> 1);
  endfunction

  function automatic logic [2:0] exp_cti(input logic [2:0] hb, input int idx);
    int len = burst_len(hb);
    if (len == 0) return 3'b000;
    return (idx == len - 1) ? 3'b111 : 3'b010;
  endfunction

  function automatic logic [1:0] exp_bte(input logic [2:0] hb);
    if (hb >= 3'd2 && !hb[0]) return 2'(hb >> 1);
    return 2'b00;
  endfunction

  function automatic logic [c_AW-1:0] beat_addr(input logic [c_AW-1:0] start, input logic [2:0] hb,
                                                input logic [2:0] sz, input int idx);
    int bytes = 1 << sz;
    int len   = burst_len(hb);
    int bound;
    int base;
    if (len != 0 && !hb[0]) begin
      bound = len * bytes;
      base  = int'(start) / bound * bound;
      return c_AW'(base + ((int'(start) - base + idx * bytes) % bound));
    end
    return c_AW'(int'(start) + idx * bytes);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [c_AW-1:0] a, input logic [2:0] sz);
    int bytes = 1 << sz;
    int base  = (int'(a) % 4) / bytes * bytes;
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= base && i < base + bytes) s[i] = 1'b1;
    return s;
  endfunction

  // ---------------- stimulus ----------------
  // Precondition: at a negedge with the bridge showing hready=1.
  // err_at: beat answered with err_i; silent: first beat never answered.
  task automatic burst(input bit wr, input logic [2:0] hb, input logic [2:0] sz,
                       input logic [c_AW-1:0] start, input int nbeats, input int busy_at,
                       input int err_at, input bit silent, input bit chain, input int fixed_wait);
    logic [c_AW-1:0] a;
    logic [c_DW-1:0] wd, rd;
    int exp_n, low, wt;
    bit is_err, quiet;
    for (int b = 0; b < nbeats; b++) begin
      a      = beat_addr(start, hb, sz, b);
      hsel   = 1'b1;
      haddr  = a;
      htrans = (b == 0) ? 2'b10 : 2'b11;
      hwrite = wr;
      hsize  = sz;
      hburst = hb;
      cyc1();
      htrans = 2'b00;
      if (sz > 3'd2) begin
        check("size_err1_hready", hready, 0);
        check("size_err1_hresp", hresp, 1);
        check("size_err1_stb", stb_o, 0);
        check("size_err1_cyc", cyc_o, 0);
        cyc1();
        check("size_err2_hready", hready, 1);
        check("size_err2_hresp", hresp, 1);
        check("size_err2_stb", stb_o, 0);
        cyc1();
        return;
      end
      check("acc_cyc", cyc_o, 1);
      check("acc_stb", stb_o, 1);
      check("acc_hready", hready, 0);
      check("acc_hresp", hresp, 0);
      check("acc_adr", adr_o, a);
      check("acc_we", we_o, wr);
      check("acc_sel", sel_o, exp_sel(a, sz));
      check("acc_cti", cti_o, exp_cti(hb, b));
      check("acc_bte", bte_o, exp_bte(hb));
      wd = $urandom;
      rd = $urandom;
      hwdata = wd;
      dat_i  = rd;
      #1;
      if (wr) check("acc_dat_o", dat_o, wd);
      is_err = (b == err_at);
      quiet  = silent && (b == 0);
      wt     = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 4);
      exp_n  = quiet ? c_TMO : wt + 1;
      low    = 0;
      for (int c = 1; c <= exp_n; c++) begin
        if (hready == 1'b0 && stb_o == 1'b1 && cyc_o == 1'b1) low++;
        if (c == exp_n && !quiet) begin
          ack_i = ~is_err;
          err_i = is_err;
        end
        cyc1();
        ack_i = 1'b0;
        err_i = 1'b0;
      end
      check("wait_cycles", low, exp_n);
      if (is_err || quiet) begin
        check("err1_hready", hready, 0);
        check("err1_hresp", hresp, 1);
        check("err1_cyc", cyc_o, 0);
        check("err1_stb", stb_o, 0);
        cyc1();
        check("err2_hready", hready, 1);
        check("err2_hresp", hresp, 1);
        cyc1();
        check("post_err_hready", hready, 1);
        check("post_err_hresp", hresp, 0);
        check("post_err_cyc", cyc_o, 0);
        return;
      end
      check("done_hready", hready, 1);
      check("done_hresp", hresp, 0);
      check("done_cyc", cyc_o, 1);
      check("done_stb", stb_o, 0);
      if (!wr) check("done_hrdata", hrdata, rd);
      if (b == busy_at && b < nbeats - 1) begin
        htrans = 2'b01;
        cyc1();
        check("busy_hready", hready, 1);
        check("busy_hresp", hresp, 0);
        check("busy_cyc", cyc_o, 1);
        check("busy_stb", stb_o, 0);
      end
    end
    if (!chain) begin
      hsel   = 1'($urandom_range(0, 1));
      htrans = hsel ? 2'b00 : 2'($urandom_range(0, 3));
      cyc1();
      check("end_cyc", cyc_o, 0);
      check("end_hready", hready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] hb, sz;
    int nb, busy, err;
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hwdata = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    repeat (3) cyc1();
    check("rst_hready", hready, 1);
    check("rst_hresp", hresp, 0);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_cti", cti_o, 0);
    check("rst_bte", bte_o, 0);
    check("rst_hrdata", hrdata, 0);
    hresetn = 1'b1;
    cyc1();

    // single write with zero-wait slave, single read with 3-cycle wait
    burst(1, 3'd0, 3'd2, 16'h0010, 1, -1, -1, 0, 0, 0);
    burst(0, 3'd0, 3'd2, 16'h0020, 1, -1, -1, 0, 0, 2);
    // WRAP4 read from 0x0C with BUSY after the second beat
    burst(0, 3'd2, 3'd2, 16'h000C, 4, 1, -1, 0, 0, -1);
    // byte and halfword lanes
    burst(1, 3'd0, 3'd0, 16'h0003, 1, -1, -1, 0, 0, -1);
    burst(1, 3'd0, 3'd1, 16'h0002, 1, -1, -1, 0, 0, -1);
    // errors: err_i on first beat, silent slave, oversize transfer
    burst(1, 3'd3, 3'd2, 16'h0100, 4, -1, 0, 0, 0, 1);
    burst(0, 3'd0, 3'd2, 16'h0200, 1, -1, -1, 1, 0, -1);
    burst(1, 3'd0, 3'd3, 16'h0300, 1, -1, -1, 0, 0, -1);
    // early termination: INCR8 cut after 3 beats, then NONSEQ WRAP8 on an open cycle
    burst(1, 3'd5, 3'd2, 16'h0400, 3, -1, -1, 0, 1, -1);
    burst(0, 3'd4, 3'd2, 16'h0514, 8, 4, -1, 0, 0, -1);

    // reset during ACCESS
    hsel = 1'b1; haddr = 16'h0040; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
    cyc1();
    check("pre_rst_stb", stb_o, 1);
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00;
    cyc1();
    check("mid_rst_cyc", cyc_o, 0);
    check("mid_rst_stb", stb_o, 0);
    check("mid_rst_hready", hready, 1);
    check("mid_rst_hresp", hresp, 0);
    hresetn = 1'b1;
    burst(1, 3'd0, 3'd2, 16'h0044, 1, -1, -1, 0, 0, -1);

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      hb = 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (hb == 3'd0)      nb = 1;
      else if (hb == 3'd1) nb = $urandom_range(1, 6);
      else                 nb = burst_len(hb);
      busy = $urandom_range(0, 3) == 0 ? $urandom_range(0, nb - 1) : -1;
      err  = $urandom_range(0, 7) == 0 ? $urandom_range(0, nb - 1) : -1;
      burst(1'($urandom_range(0, 1)), hb, sz,
            c_AW'($urandom_range(0, 16'hFFFF) & ~((1 << sz) - 1)),
            nb, busy, err, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, -1);
    end
    hsel = 1'b0; htrans = 2'b00;
    cyc1();
    check("final_cyc", cyc_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb2wb_burst.md
Name: ahb2wb_burst

Overview:
AHB-Lite slave to Wishbone B3 master bridge, successor to the single-transfer bridge. Adds:
- Parameterised data width and byte lanes (sel_o from hsize/haddr).
- Fixed-length and wrapping bursts mapped to Wishbone registered-feedback cycles (cti_o/bte_o).
- BUSY handling, ERROR responses from err_i, and a Wishbone ack timeout.
- One clock domain; sits between the AHB interconnect and one Wishbone slave.

Parameters:
- AWIDTH, 16: address width of haddr and adr_o.
- DWIDTH, 32: data width; 32 or 64 only; byte lanes NSEL = DWIDTH/8.
- TIMEOUT, 255: max cycles in ACCESS waiting for ack_i/err_i; 0 disables the timeout.

Ports:
- hclk  in  1  clock, both buses
- hresetn  in  1  synchronous active-low reset
- hsel  in  1  slave select
- haddr  in  AWIDTH  AHB address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  burst type
- hwdata  in  DWIDTH  write data
- hrdata  out  DWIDTH  read data
- hready  out  1  transfer done / slave ready
- hresp  out  2  00 = OKAY, 01 = ERROR
- adr_o  out  AWIDTH  WB address
- dat_o  out  DWIDTH  WB write data
- dat_i  in  DWIDTH  WB read data
- sel_o  out  NSEL  WB byte selects
- we_o  out  1  WB write enable
- cyc_o  out  1  WB cycle
- stb_o  out  1  WB strobe
- cti_o  out  3  WB cycle type identifier
- bte_o  out  2  WB burst type extension
- ack_i  in  1  WB acknowledge
- err_i  in  1  WB error

Behaviour:
- Reset: sampled on posedge hclk only when hresetn=0.
  - cyc_o=stb_o=we_o=0; adr_o, sel_o, cti_o, bte_o, hrdata = 0; hready=1; hresp=00; state IDLE; beat and timeout counters 0.
  - Reset mid-access drops cyc_o/stb_o on that same edge and abandons the transfer. No ack is owed.
- Accept: an address phase is taken when hsel & hready & htrans[1].
  - On that edge, register haddr into adr_o, hwrite into we_o, and sel_o, cti_o, bte_o.
  - Assert cyc_o=stb_o=1 and go to ACCESS.
- States: IDLE, ACCESS, DONE, ERR1, ERR2.
- IDLE: hready=1, hresp=00, cyc_o=0.
- ACCESS: hready=0.
  - dat_o = hwdata combinationally; hwdata is stable because hready=0.
  - Timeout counter increments each cycle.
  - ack_i: capture dat_i into hrdata if reading, stb_o=0, go DONE.
  - err_i, or timeout count reaching TIMEOUT: stb_o=0, cyc_o=0, go ERR1.
  - err_i wins over ack_i if both are high.
- DONE: hready=1, hresp=00.
  - New accept: re-enter ACCESS with stb_o=1 and cyc_o held; this is one data-phase wait state minimum per beat.
  - htrans=BUSY with hsel: hold cyc_o=1, stb_o=0, stay DONE with zero-wait OKAY.
  - IDLE or ~hsel: cyc_o=0, go IDLE.
- ERR1: hready=0, hresp=01. ERR2 (next cycle): hready=1, hresp=01. Then IDLE, or ACCESS if an accept occurs in ERR2.
- Size check: hsize encoding > log2(NSEL) is answered ERR1/ERR2 directly, with no WB cycle.
- sel_o: byte → one lane at haddr low bits; half → two lanes, aligned; word → 4 lanes; dword (DWIDTH=64) → all lanes. Lane 0 is LSB.
- adr_o is always haddr; the AHB master supplies every beat's address, so there is no internal increment.
- cti_o:
  - SINGLE and INCR (undefined length): 000.
  - INCR4/8/16 and WRAP4/8/16: 010 on every beat except the last (beat counter = 3/7/15), which gets 111.
  - Beat counter resets on NONSEQ and increments on each accepted SEQ.
- bte_o: 00 for INCRx; WRAP4 → 01, WRAP8 → 10, WRAP16 → 11.
- A NONSEQ arriving mid-burst (early termination) restarts the beat counter. The WB cycle stays continuous; cyc_o is not dropped.
- DWIDTH ≠ 32/64 is unsupported; the bridge does not check for it.

Test Plan:
1. Single write, zero-wait slave: NONSEQ haddr=0x0010, hsize=010, hwdata=0xDEADBEEF → next cycle adr_o=0x0010, we_o=1, sel_o=1111, dat_o=0xDEADBEEF, cti_o=000, hready=0. ack_i in that cycle → hready=1/OKAY the following cycle, then cyc_o=0.
2. Single read, slave acks after 3 cycles with dat_i=0x12345678 → hready low for 3 cycles, then hrdata=0x12345678 with hready=1, hresp=00.
3. WRAP4 read starting at 0x000C → adr_o sequence 0C, 00, 04, 08; cti_o 010, 010, 010, 111; bte_o=01; cyc_o continuous; BUSY inserted after beat 2 → stb_o=0, cyc_o=1, zero-wait OKAY.
4. Byte write at haddr=0x0003, hsize=000 → sel_o=1000. Halfword at 0x0002 → sel_o=1100.
5. Errors: err_i on beat 1 → hresp=01 with hready=0, then hresp=01 with hready=1, cyc_o=0. Slave silent with TIMEOUT=8 → ERROR after 8 ACCESS cycles. hsize=011 with DWIDTH=32 → ERROR, stb_o never asserted.
6. hresetn=0 during ACCESS → next edge cyc_o=stb_o=0, hready=1, hresp=00; a subsequent NONSEQ is accepted normally.
